// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester data bus arbiter.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    ACK   = 2'b11
  } state_t;

  localparam int unsigned REQ_CPU         = 0;
  localparam int unsigned REQ_VGA         = 1;
  localparam int unsigned MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker: the requester that was not served last wins a tie.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Arbitrates a CPU and a VGA/debug reader onto one data memory port with fixed read latency.
// Handshake: iReq[n] is a level held until oAck[n]; oAck is a one-cycle pulse and oRData is valid only with it.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
  parameter int unsigned AW      = 64
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [1:0]    iReq,
  input  logic [1:0]    iWrite,
  input  logic [AW-1:0] iAddr0,
  input  logic [AW-1:0] iAddr1,
  input  logic [AW-1:0] iWData0,
  input  logic [AW-1:0] iWData1,
  input  logic [3:0]    iBE0,
  input  logic [3:0]    iBE1,
  output logic [1:0]    oAck,
  output logic [AW-1:0] oRData,
  output logic [1:0]    oGrant,
  output logic          wReadEnable,
  output logic          wWriteEnable,
  output logic [3:0]    wByteEnable,
  output logic [AW-1:0] wAddress,
  output logic [AW-1:0] wWriteData,
  input  logic [AW-1:0] wReadData,
  output logic [1:0]    oState
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          ptr_q;
  logic          owner_q;
  logic          write_q;
  logic [1:0]    grant_q;
  logic [1:0]    ack_q;
  logic [AW-1:0] rdata_q;
  logic          re_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] wdata_q;

  logic [1:0]    pick;
  logic          win_id;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] sel_wdata;
  logic [3:0]    sel_be;

  arb_rr2 u_pick (
    .req_i (iReq),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  assign win_id    = pick[REQ_VGA];
  assign sel_write = iWrite[win_id];
  assign sel_addr  = win_id ? iAddr1  : iAddr0;
  assign sel_wdata = win_id ? iWData1 : iWData0;
  assign sel_be    = win_id ? iBE1    : iBE0;

  // Memory-side registers double as the request latch; they are only non-zero during ISSUE.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'(REQ_VGA);
      owner_q <= 1'b0;
      write_q <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|iReq) begin
            state_q <= ISSUE;
            owner_q <= win_id;
            write_q <= sel_write;
            grant_q <= pick;
            rdata_q <= '0;
            re_q    <= ~sel_write;
            we_q    <= sel_write;
            be_q    <= sel_be;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= LAT_M1;
          re_q    <= 1'b0;
          we_q    <= 1'b0;
          be_q    <= '0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ACK;
            ptr_q   <= owner_q;
            ack_q   <= grant_q;
            if (!write_q) rdata_q <= wReadData;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oAck         = ack_q;
  assign oRData       = rdata_q;
  assign oGrant       = grant_q;
  assign wReadEnable  = re_q;
  assign wWriteEnable = we_q;
  assign wByteEnable  = be_q;
  assign wAddress     = addr_q;
  assign wWriteData   = wdata_q;
  assign oState       = state_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: two instances (MEM_LAT 1 and 4), a transaction-level model and directed scenarios.
module tb_data_bus_arbiter;
  localparam int AW = 64;
  localparam logic [AW-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    req   [2];
  logic [1:0]    wr    [2];
  logic [AW-1:0] addr0 [2];
  logic [AW-1:0] addr1 [2];
  logic [AW-1:0] wd0   [2];
  logic [AW-1:0] wd1   [2];
  logic [3:0]    be0   [2];
  logic [3:0]    be1   [2];
  logic [1:0]    ack   [2];
  logic [AW-1:0] rdata [2];
  logic [1:0]    gnt   [2];
  logic          mre   [2];
  logic          mwe   [2];
  logic [3:0]    mbe   [2];
  logic [AW-1:0] maddr [2];
  logic [AW-1:0] mwd   [2];
  logic [AW-1:0] mrd   [2];
  logic [1:0]    st    [2];

  int checks   = 0;
  int failures = 0;
  int lat_c [2] = '{1, 4};

  data_bus_arbiter #(.MEM_LAT(1), .AW(AW)) dut_l1 (
    .iCLK(clk), .iRST(rst), .iReq(req[0]), .iWrite(wr[0]),
    .iAddr0(addr0[0]), .iAddr1(addr1[0]), .iWData0(wd0[0]), .iWData1(wd1[0]),
    .iBE0(be0[0]), .iBE1(be1[0]), .oAck(ack[0]), .oRData(rdata[0]), .oGrant(gnt[0]),
    .wReadEnable(mre[0]), .wWriteEnable(mwe[0]), .wByteEnable(mbe[0]),
    .wAddress(maddr[0]), .wWriteData(mwd[0]), .wReadData(mrd[0]), .oState(st[0])
  );

  data_bus_arbiter #(.MEM_LAT(4), .AW(AW)) dut_l4 (
    .iCLK(clk), .iRST(rst), .iReq(req[1]), .iWrite(wr[1]),
    .iAddr0(addr0[1]), .iAddr1(addr1[1]), .iWData0(wd0[1]), .iWData1(wd1[1]),
    .iBE0(be0[1]), .iBE1(be1[1]), .oAck(ack[1]), .oRData(rdata[1]), .oGrant(gnt[1]),
    .wReadEnable(mre[1]), .wWriteEnable(mwe[1]), .wByteEnable(mbe[1]),
    .wAddress(maddr[1]), .wWriteData(mwd[1]), .wReadData(mrd[1]), .oState(st[1])
  );

  // ---------------- memory: data valid only MEM_LAT cycles after the read strobe ----------------
  function automatic logic [AW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 64'h1000_0010) return 64'hDEAD_BEEF;
    return {a[31:0] ^ 32'h5A5A_5A5A, a[31:0]};
  endfunction

  int            mem_cnt [2] = '{0, 0};
  logic [AW-1:0] mem_q   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mre[i]) begin
        mem_cnt[i] <= lat_c[i];
        mem_q[i]   <= mem_val(maddr[i]);
      end else if (mem_cnt[i] != 0) begin
        mem_cnt[i] <= mem_cnt[i] - 1;
      end
    end
  end

  assign mrd[0] = (mem_cnt[0] == 1) ? mem_q[0] : JUNK;
  assign mrd[1] = (mem_cnt[1] == 1) ? mem_q[1] : JUNK;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int inst, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Each transaction occupies cycles t=1 (strobe) .. t=lat+2 (ack) after capture.
  bit            m_on = 1'b0;
  bit            m_busy [2];
  int            m_t    [2];
  bit            m_last [2];
  bit            m_own  [2];
  bit            m_w    [2];
  logic [AW-1:0] m_addr [2];
  logic [AW-1:0] m_wd   [2];
  logic [AW-1:0] m_rd   [2];
  logic [3:0]    m_be   [2];

  always @(posedge clk) begin
    if (rst) m_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0; m_t[i] = 0; m_last[i] = 1'b1; m_rd[i] = '0;
      end else if (!m_busy[i]) begin
        if (req[i] != 2'b00) begin
          m_own[i]  = (req[i] == 2'b11) ? !m_last[i] : req[i][1];
          m_w[i]    = wr[i][m_own[i]];
          m_addr[i] = m_own[i] ? addr1[i] : addr0[i];
          m_wd[i]   = m_own[i] ? wd1[i]   : wd0[i];
          m_be[i]   = m_own[i] ? be1[i]   : be0[i];
          m_busy[i] = 1'b1;
          m_t[i]    = 1;
        end
      end else if (m_t[i] == lat_c[i] + 2) begin
        m_busy[i] = 1'b0;
        m_t[i]    = 0;
      end else begin
        m_t[i]++;
        if (m_t[i] == lat_c[i] + 2) begin
          m_last[i] = m_own[i];
          m_rd[i]   = m_w[i] ? '0 : mem_val(m_addr[i]);
        end
      end
    end
  end

  logic [1:0] e_oh;
  logic [1:0] e_st;
  bit         e_iss;
  bit         e_ack;

  always @(negedge clk) begin
    if (m_on) begin
      for (int i = 0; i < 2; i++) begin
        e_oh  = m_own[i] ? 2'b10 : 2'b01;
        e_iss = m_busy[i] && (m_t[i] == 1);
        e_ack = m_busy[i] && (m_t[i] == lat_c[i] + 2);
        e_st  = !m_busy[i] ? 2'd0 : e_iss ? 2'd1 : e_ack ? 2'd3 : 2'd2;
        chk("grant", i, AW'(gnt[i]), AW'(m_busy[i] ? e_oh : 2'b00));
        chk("ack",   i, AW'(ack[i]), AW'(e_ack ? e_oh : 2'b00));
        chk("rd_en", i, AW'(mre[i]), AW'(e_iss && !m_w[i]));
        chk("wr_en", i, AW'(mwe[i]), AW'(e_iss && m_w[i]));
        chk("be",    i, AW'(mbe[i]), AW'(e_iss ? m_be[i] : 4'h0));
        chk("addr",  i, maddr[i], e_iss ? m_addr[i] : '0);
        chk("wdata", i, mwd[i],   e_iss ? m_wd[i] : '0);
        chk("state", i, AW'(st[i]), AW'(e_st));
        if (e_ack) chk("rdata", i, rdata[i], m_rd[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int i, output logic [1:0] a, output int n);
    a = 2'b00;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ack[i] != 2'b00) begin
        a = ack[i];
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL ack_timeout inst%0d actual=no_ack required=ack_within_40", i);
  endtask

  // ---------------- directed scenarios ----------------
  logic [1:0] a;
  int         nc;
  int         we_cnt, we_at, ack_at, cnt0;
  logic [1:0] ackv;
  logic [AW-1:0] rdv;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = '0; wr[i] = '0; addr0[i] = '0; addr1[i] = '0;
      wd0[i] = '0; wd1[i] = '0; be0[i] = '0; be1[i] = '0;
    end
    repeat (3) tick();

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack",   i, AW'(ack[i]), '0);
      chk("rst_grant", i, AW'(gnt[i]), '0);
      chk("rst_rdata", i, rdata[i], '0);
      chk("rst_strobe", i, AW'({mre[i], mwe[i]}), '0);
      chk("rst_addr",  i, maddr[i], '0);
    end

    // Contention from the first cycle after reset: CPU reads, VGA writes.
    tick();
    rst = 1'b0;
    addr0[0] = 64'h100; addr1[0] = 64'h200; wd1[0] = 64'h77;
    be0[0] = 4'hF; be1[0] = 4'h3; wr[0] = 2'b10; req[0] = 2'b11;
    for (int n = 0; n < 6; n++) begin
      wait_ack(0, a, nc);
      chk("cont_order", n, AW'(a), AW'((n % 2 == 0) ? 2'b01 : 2'b10));
      chk("cont_spacing", n, AW'(nc), AW'(4));
      tick();
      if (n == 5) req[0] = 2'b00;
      else if (a == 2'b01) addr0[0] = addr0[0] + 64'h8;
      else begin addr1[0] = addr1[0] + 64'h8; wd1[0] = wd1[0] + 64'h1; end
    end

    // CPU-only read with MEM_LAT=1.
    tick(); tick();
    wr[0] = 2'b00; addr0[0] = 64'h1000_0010; req[0] = 2'b01;
    @(negedge clk); chk("r033_no_strobe", 0, AW'(mre[0]), '0);
    @(negedge clk); chk("r033_strobe", 0, AW'(mre[0]), AW'(1'b1));
                    chk("r033_addr", 0, maddr[0], 64'h1000_0010);
    @(negedge clk); chk("r033_no_ack", 0, AW'(ack[0]), '0);
    @(negedge clk); chk("r033_ack", 0, AW'(ack[0]), AW'(2'b01));
                    chk("r033_rdata", 0, rdata[0], 64'hDEAD_BEEF);
    tick(); req[0] = 2'b00;

    // CPU drops after capture; a short VGA request outside IDLE is ignored.
    tick(); tick();
    addr0[0] = 64'h2000; req[0] = 2'b01;
    tick(); req[0] = 2'b00;
    tick(); req[0] = 2'b10;
    @(negedge clk); chk("r038_no_ack_yet", 0, AW'(ack[0]), '0);
    tick(); req[0] = 2'b00;
    @(negedge clk); chk("r038_ack", 0, AW'(ack[0]), AW'(2'b01));
    cnt0 = 0;
    repeat (6) begin @(negedge clk); if (ack[0] != 2'b00) cnt0++; end
    chk("r025_ignored", 0, AW'(cnt0), '0);

    // VGA write with MEM_LAT=4.
    tick();
    wr[1] = 2'b10; addr1[1] = 64'h40; wd1[1] = 64'h55; be1[1] = 4'hF; req[1] = 2'b10;
    we_cnt = 0; we_at = -1; ack_at = -1; ackv = '0; rdv = JUNK;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (mwe[1]) begin we_cnt++; we_at = c; end
      if (ack[1] != 2'b00 && ack_at < 0) begin
        ack_at = c; ackv = ack[1]; rdv = rdata[1]; req[1] = 2'b00;
      end
    end
    chk("r036_we_count", 1, AW'(we_cnt), AW'(1));
    chk("r036_we_cycle", 1, AW'(we_at), AW'(1));
    chk("r036_ack_cycle", 1, AW'(ack_at), AW'(6));
    chk("r036_ack", 1, AW'(ackv), AW'(2'b10));
    chk("r036_rdata", 1, rdv, '0);

    // Reset during WAIT aborts a CPU write with no ack and no re-issue.
    tick();
    wr[1] = 2'b01; addr0[1] = 64'h300; wd0[1] = 64'h99; be0[1] = 4'h1; req[1] = 2'b01;
    tick(); tick(); tick();
    rst = 1'b1; req[1] = 2'b00;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("r037_state_idle", 1, AW'(st[1]), '0);
    chk("r037_grant", 1, AW'(gnt[1]), '0);
    cnt0 = 0;
    repeat (6) begin @(negedge clk); if (ack[1] != 2'b00 || mwe[1]) cnt0++; end
    chk("r037_no_ack_no_reissue", 1, AW'(cnt0), '0);

    tick();
    wr[1] = 2'b00; addr0[1] = 64'h1000_0010; req[1] = 2'b01;
    wait_ack(1, a, nc);
    chk("r037_new_ack", 1, AW'(a), AW'(2'b01));
    chk("r037_new_latency", 1, AW'(nc), AW'(7));
    chk("r037_new_rdata", 1, rdata[1], 64'hDEAD_BEEF);
    tick(); req[1] = 2'b00;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, data memory read latency in cycles (legal 1..15).
REQ-002 Parameter AW, default 64, address/data width.
REQ-003 iCLK  in  1  clock; sole clock; all state updates on rising edge.
REQ-004 iRST  in  1  reset; synchronous, active-high.
REQ-005 iReq  in  2  request per requester (bit0 = CPU, bit1 = VGA/debug reader); level, held until ack.
REQ-006 iWrite  in  2  per-requester write flag (1 = write, 0 = read).
REQ-007 iAddr0, iAddr1  in  AW each  per-requester byte address.
REQ-008 iWData0, iWData1  in  AW each  per-requester write data.
REQ-009 iBE0, iBE1  in  4 each  per-requester byte enable.
REQ-010 oAck  out  2  one-cycle completion pulse per requester.
REQ-011 oRData  out  AW  read data; valid only in an oAck cycle.
REQ-012 oGrant  out  2  one-hot current owner; 0 when idle.
REQ-013 wReadEnable, wWriteEnable  out  1 each  memory strobes.
REQ-014 wByteEnable  out  4;  wAddress, wWriteData  out  AW;  wReadData  in  AW  memory port.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, ACK, with 2-bit encoding 00/01/10/11.
REQ-016 IDLE: any iReq bit set -> select winner, latch its write flag, address, data and BE, go to ISSUE; otherwise stay.
REQ-017 Winner: single requester wins alone; on both set, requester != last-served pointer wins (round-robin).
REQ-018 The last-served pointer resets to 1, so CPU wins the first contention after reset; it updates on entry to ACK.
REQ-019 ISSUE: exactly one cycle with wReadEnable=~write or wWriteEnable=write driven from latched values, then WAIT with counter loaded to MEM_LAT-1.
REQ-020 WAIT: counter decrements each cycle; at counter 0, capture wReadData into oRData register (reads only), go to ACK.
REQ-021 ACK: oAck[owner]=1 for one cycle, then IDLE; oRData for writes is 0.
REQ-022 Latency: request first seen in IDLE at cycle k -> memory strobe at k+1 -> oAck at k+2+MEM_LAT.
REQ-023 Memory strobes, wAddress, wWriteData and wByteEnable are 0 outside ISSUE.
REQ-024 oGrant is one-hot from ISSUE through ACK inclusive.
REQ-025 A request dropped before IDLE samples it is ignored; one dropped after capture still completes and is acked.
REQ-026 A requester re-asserting in the cycle after its ack competes normally; under continuous contention the grants strictly alternate.
REQ-027 Request inputs are ignored outside IDLE; there is no pre-emption.

Reset
REQ-028 iRST=1 at an edge -> state IDLE, counter 0, pointer 1, all latches 0.
REQ-029 During reset, outputs oAck, oGrant, oRData, wReadEnable, wWriteEnable, wByteEnable, wAddress and wWriteData are 0.
REQ-030 Reset mid-transaction aborts it with no ack; the memory write is not re-issued.

Structure
REQ-031 The shared package holds the FSM state type/encoding, the requester IDs REQ_CPU=0 and REQ_VGA=1, and the default MEM_LAT.
REQ-032 One sub-module, arb_rr2, holds the combinational 2-way round-robin picker (inputs: req, pointer; output: one-hot grant); everything else stays in data_bus_arbiter.

Verification
REQ-033 CPU-only read, addr 0x1000_0010, MEM_LAT=1, memory returns 0xDEAD_BEEF -> strobe 1 cycle after request, oAck=01 3 cycles after request, oRData=0xDEAD_BEEF.
REQ-034 Both request in the first cycle after reset -> CPU served first, VGA next.
REQ-035 Continuous contention for 6 transactions -> grant order CPU, VGA, CPU, VGA, CPU, VGA.
REQ-036 VGA write, BE=0xF, data 0x55, with MEM_LAT=4 -> wWriteEnable high exactly 1 cycle, oAck=10 6 cycles after request, oRData=0.
REQ-037 iRST asserted in WAIT -> no oAck; IDLE next cycle; a new CPU request is served normally.
REQ-038 CPU drops its request one cycle after IDLE captures it -> transaction still completes and oAck[0] pulses.
